// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
//   Two requesters share one bitwise logic unit (OR/AND/XOR/NOR). A round-robin
//   grant picks one requester per cycle, and the result lands in a one-entry
//   registered buffer that is tagged with the issuing requester's id.
//   Ports:
//     clk, reset                    clock, synchronous active-high reset
//     reqN_valid/reqN_ready         request handshake for requester N (0,1)
//     reqN_op, reqN_a, reqN_b       op (00 OR, 01 AND, 10 XOR, 11 NOR), operands
//     rsp_valid/rsp_ready           result buffer handshake
//     rsp_data, rsp_id              buffered result and its requester id
//     busy                          result held or any request pending
module logic_unit_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             busy
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             id_q, id_d;

  logic             gnt_any;
  logic             gnt_id;
  logic             can_accept;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] result;

  always_comb begin
    // Contention goes to whoever was not served last; otherwise the lone
    // valid requester wins. Neither ready depends on the other ready.
    gnt_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) gnt_id = ~last_grant_q;
    else                          gnt_id = req1_valid;

    // A drain in the same cycle frees the buffer for an immediate refill.
    can_accept = (state_q == EMPTY) | (rsp_ready & (state_q == FULL));

    req0_ready = can_accept & gnt_any & ~gnt_id;
    req1_ready = can_accept & gnt_any &  gnt_id;

    sel_op = gnt_id ? req1_op : req0_op;
    sel_a  = gnt_id ? req1_a  : req0_a;
    sel_b  = gnt_id ? req1_b  : req0_b;

    case (sel_op)
      2'b00:   result = sel_a | sel_b;
      2'b01:   result = sel_a & sel_b;
      2'b10:   result = sel_a ^ sel_b;
      default: result = ~(sel_a | sel_b);
    endcase

    state_d      = state_q;
    last_grant_d = last_grant_q;
    data_d       = data_q;
    id_d         = id_q;
    if (can_accept && gnt_any) begin
      state_d      = FULL;
      data_d       = result;
      id_d         = gnt_id;
      last_grant_d = gnt_id;
    end else if (state_q == FULL && rsp_ready) begin
      // Drain only: data and id keep their last value.
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= EMPTY;
      last_grant_q <= 1'b1;
      data_q       <= '0;
      id_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      data_q       <= data_d;
      id_q         <= id_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign busy      = rsp_valid | req0_valid | req1_valid;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: directed scenarios plus a
// randomized run scored against per-requester queues.
module tb_logic_unit_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready;
  logic [1:0]  req0_op;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready;
  logic [1:0]  req1_op;
  logic [31:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_id;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  logic_unit_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .busy(busy)
  );

  function automatic logic [31:0] ref_f(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'd0:    return a | b;
      2'd1:    return a & b;
      2'd2:    return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_op = 2'd0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = 2'd0; req1_a = '0; req1_b = '0;
    rsp_ready  = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b%b exp=00", req0_ready, req1_ready); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy cycle=%0d got=%b exp=0", i, busy); end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_or();
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 2'd0; req0_a = 32'hF0F0_0000; req0_b = 32'h0000_0F0F;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL or_ready got=%b%b exp=10", req0_ready, req1_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL or_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_data !== 32'hF0F0_0F0F) begin failures++; $display("FAIL or_rsp_data got=%h exp=f0f00f0f", rsp_data); end
    checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL or_rsp_id got=%b exp=0", rsp_id); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL or_drain got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_alternate();
    logic [1:0]  op0 [3];
    logic [31:0] a0 [3], b0 [3], e0 [3];
    logic [1:0]  op1 [3];
    logic [31:0] a1 [3], b1 [3], e1 [3];
    int i0, i1, g;
    logic [31:0] exp_data;
    logic        exp_id;
    op0 = '{2'd3, 2'd1, 2'd0};
    a0  = '{32'h0, 32'hFFFF_0000, 32'h0};
    b0  = '{32'h0, 32'h0F0F_0F0F, 32'h0};
    e0  = '{32'hFFFF_FFFF, 32'h0F0F_0000, 32'h0};
    op1 = '{2'd2, 2'd0, 2'd0};
    a1  = '{32'hDEAD_BEEF, 32'h1234_0000, 32'h0};
    b1  = '{32'hDEAD_BEEF, 32'h0000_5678, 32'h0};
    e1  = '{32'h0, 32'h1234_5678, 32'h0};
    i0 = 0; i1 = 0; exp_data = '0; exp_id = 1'b0;
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      if (c != 0) @(negedge clk);
      rsp_ready  = 1'b1;
      req0_valid = 1'b1; req0_op = op0[i0]; req0_a = a0[i0]; req0_b = b0[i0];
      req1_valid = 1'b1; req1_op = op1[i1]; req1_a = a1[i1]; req1_b = b1[i1];
      #1;
      g = c % 2;
      checks++; if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin failures++; $display("FAIL alt_grant cycle=%0d got=%b%b exp_grantee=%0d", c, req0_ready, req1_ready, g); end
      if (c != 0) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_data !== exp_data) begin failures++; $display("FAIL alt_rsp cycle=%0d got=%b/%b/%h exp=1/%b/%h", c, rsp_valid, rsp_id, rsp_data, exp_id, exp_data); end
      end
      exp_id = g[0];
      if (g == 0) begin exp_data = e0[i0]; i0++; end
      else        begin exp_data = e1[i1]; i1++; end
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_data !== exp_data) begin failures++; $display("FAIL alt_last got=%b/%b/%h exp=1/%b/%h", rsp_valid, rsp_id, rsp_data, exp_id, exp_data); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 2'd2; req0_a = 32'hAAAA_5555; req0_b = 32'hFFFF_0000;
    rsp_ready = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 2'd1; req1_a = 32'h1234_5678; req1_b = 32'h0000_FFFF;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h5555_5555 || rsp_id !== 1'b0) begin failures++; $display("FAIL bp_hold cycle=%0d got=%b/%h/%b exp=1/55555555/0", i, rsp_valid, rsp_data, rsp_id); end
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin failures++; $display("FAIL bp_ready cycle=%0d got=%b%b exp=00", i, req0_ready, req1_ready); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin failures++; $display("FAIL bp_refill_ready got=%b%b exp=01", req0_ready, req1_ready); end
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 32'h0000_5678) begin failures++; $display("FAIL bp_refill_rsp got=%b/%b/%h exp=1/1/00005678", rsp_valid, rsp_id, rsp_data); end
  endtask

  task automatic test_reset_midop();
    apply_reset();
    @(negedge clk);
    req1_valid = 1'b1; req1_op = 2'd0; req1_a = 32'h0000_00F0; req1_b = 32'h0000_000F;
    rsp_ready = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 32'h0000_00FF) begin failures++; $display("FAIL mid_fill got=%b/%b/%h exp=1/1/000000ff", rsp_valid, rsp_id, rsp_data); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_data !== 32'h0) begin failures++; $display("FAIL mid_reset got=%b/%b/%h exp=0/0/0", rsp_valid, rsp_id, rsp_data); end
    reset = 1'b0;
    req0_valid = 1'b1; req0_op = 2'd0; req0_a = 32'h1; req0_b = 32'h2;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL mid_first_grant got=%b%b exp=10", req0_ready, req1_ready); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_random();
    logic [65:0] q0[$], q1[$];
    logic [65:0] ent;
    logic        acc0, acc1, model_last, exp_rv, canacc, g, any, gen;
    logic        prev_stall, prev_id;
    logic [31:0] prev_data;
    int          outstanding, wait0, wait1;
    acc0 = 1'b0; acc1 = 1'b0; model_last = 1'b1; prev_stall = 1'b0;
    prev_id = 1'b0; prev_data = '0; outstanding = 0; wait0 = 0; wait1 = 0;
    apply_reset();
    for (int cyc = 0; cyc < 10010; cyc++) begin
      gen = (cyc < 10000);
      if (cyc != 0) @(negedge clk);
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
      if (gen && !req0_valid && $urandom_range(0, 3) != 0) begin
        req0_valid = 1'b1; req0_op = 2'($urandom); req0_a = $urandom; req0_b = $urandom;
      end
      if (gen && !req1_valid && $urandom_range(0, 3) != 0) begin
        req1_valid = 1'b1; req1_op = 2'($urandom); req1_a = $urandom; req1_b = $urandom;
      end
      rsp_ready = gen ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      exp_rv = (outstanding != 0);
      canacc = !exp_rv || rsp_ready;
      any    = req0_valid || req1_valid;
      g      = (req0_valid && req1_valid) ? !model_last : req1_valid;
      checks++; if (rsp_valid !== exp_rv) begin failures++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_rv); end
      checks++; if (req0_ready !== (canacc && any && !g) || req1_ready !== (canacc && any && g)) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b%b exp=%b%b", cyc, req0_ready, req1_ready, canacc && any && !g, canacc && any && g); end
      checks++; if (busy !== (exp_rv || any)) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_rv || any); end
      if (prev_stall) begin
        checks++; if (rsp_data !== prev_data || rsp_id !== prev_id) begin failures++; $display("FAIL rnd_stable cyc=%0d got=%h/%b exp=%h/%b", cyc, rsp_data, rsp_id, prev_data, prev_id); end
      end
      if (exp_rv && rsp_ready) begin
        checks++;
        if ((rsp_id ? q1.size() : q0.size()) == 0) begin
          failures++; $display("FAIL rnd_dup cyc=%0d id=%b got=%h exp=no_response", cyc, rsp_id, rsp_data);
        end else begin
          ent = rsp_id ? q1.pop_front() : q0.pop_front();
          if (rsp_data !== ref_f(ent[65:64], ent[63:32], ent[31:0])) begin
            failures++; $display("FAIL rnd_data cyc=%0d id=%b got=%h exp=%h", cyc, rsp_id, rsp_data, ref_f(ent[65:64], ent[63:32], ent[31:0]));
          end
        end
        outstanding--;
      end
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      if (acc0) begin q0.push_back({req0_op, req0_a, req0_b}); model_last = 1'b0; outstanding++; end
      if (acc1) begin q1.push_back({req1_op, req1_a, req1_b}); model_last = 1'b1; outstanding++; end
      if (acc0 || acc1) begin
        if (acc0) wait0 = 0; else if (req0_valid) wait0++;
        if (acc1) wait1 = 0; else if (req1_valid) wait1++;
      end
      checks++; if (wait0 > 1 || wait1 > 1) begin failures++; $display("FAIL rnd_starve cyc=%0d got=%0d/%0d exp_max=1", cyc, wait0, wait1); end
      prev_stall = rsp_valid && !rsp_ready;
      prev_data  = rsp_data;
      prev_id    = rsp_id;
    end
    checks++; if (q0.size() != 0 || q1.size() != 0 || outstanding != 0) begin failures++; $display("FAIL rnd_loss got=%0d/%0d/%0d exp=0/0/0", q0.size(), q1.size(), outstanding); end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_or();
    test_alternate();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
